seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, clock cycles each digit is lit per scan slot.
REQ-002 SHALL have parameter GAP_CYCLES, default 1, all-dark cycles between digit slots (anti-ghosting).
REQ-003 SHALL have parameter BLINK_HALF, default 250, clock cycles per blink on-phase and per off-phase.
REQ-004 SHALL have port clk_1khz_i, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port seg_tens_i, input, 7, tens-digit segment pattern from the scoreboard display decoder (bit0=a … bit6=g, 1=lit).
REQ-007 SHALL have port seg_ones_i, input, 7, ones-digit segment pattern, same encoding.
REQ-008 SHALL have port blank_lz_i, input, 1, high enables leading-zero blanking of the tens digit.
REQ-009 SHALL have port blink_i, input, 1, high requests blinking of the whole display.
REQ-010 SHALL have port seg_o, output, 7, shared segment bus to both digits, same encoding.
REQ-011 SHALL have port dig_en_o, output, 2, digit common enables, one-hot or zero; bit1=tens, bit0=ones.
REQ-012 SHALL have port frame_o, output, 1, one-cycle pulse at every frame boundary.

Function
REQ-013 SHALL be a Moore FSM with states TENS, GAP_A, ONES, GAP_B, visited in that order and wrapping GAP_B→TENS.
REQ-014 SHALL remain DWELL_CYCLES cycles in TENS and ONES, and GAP_CYCLES cycles in GAP_A and GAP_B; frame length = 2·(DWELL_CYCLES+GAP_CYCLES), 10 cycles at defaults.
REQ-015 SHALL skip both gap states when GAP_CYCLES=0 (TENS→ONES→TENS).
REQ-016 SHALL capture seg_tens_i, seg_ones_i, blank_lz_i into shadow registers only on the cycle the FSM enters TENS, so one frame never mixes old and new values.
REQ-017 SHALL drive from registers: TENS → dig_en_o=2'b10, seg_o=tens shadow; ONES → dig_en_o=2'b01, seg_o=ones shadow; gap states → dig_en_o=2'b00, seg_o=7'h00.
REQ-018 SHALL force dig_en_o=2'b00 and seg_o=7'h00 during TENS when the blank_lz shadow is 1 and the tens shadow equals 7'h3F (digit "0").
REQ-019 SHALL pulse frame_o high for exactly the first cycle of each TENS state.
REQ-020 SHALL run a blink counter 0..2·BLINK_HALF−1 wrapping to 0, free-running while blink_i=1, cleared to 0 while blink_i=0.
REQ-021 SHALL force dig_en_o=2'b00 and seg_o=7'h00 while blink_i=1 and counter ≥ BLINK_HALF; the FSM and frame_o are unaffected by blanking.
REQ-022 SHALL never assert both dig_en_o bits in the same cycle, including across state transitions.
REQ-023 SHALL use a dwell/gap counter sized $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1) bits; DWELL_CYCLES≥1 is required.

Reset
REQ-024 SHALL on rst_ni=0 immediately set state=TENS, dwell counter=0, blink counter=0, shadows=7'h00 / 0, seg_o=7'h00, dig_en_o=2'b00, frame_o=0, regardless of clock.
REQ-025 SHALL on the first rising edge after rst_ni deasserts capture the shadows and assert frame_o, starting a full TENS slot.
REQ-026 SHALL, if reset asserts mid-frame or mid-blink, discard the partial frame with no residual enable pulse.

Structure
REQ-027 SHALL place the FSM state encoding and the constant SEG_ZERO=7'h3F in the shared scoreboard package, also used by the segment decoder.
REQ-028 SHALL implement the blink counter as sub-module blink_gen (inputs clk, rst_ni, enable; output off_phase).
REQ-029 SHALL be instantiated in scoreboard_top downstream of the dual-digit segment decoder, driving the physical pins.

Verification
REQ-030 SHALL verify scan order: tens=7'h06, ones=7'h5B, defaults → repeating 10-cycle pattern 4×(10,06), 1×(00,00), 4×(01,5B), 1×(00,00) on (dig_en_o,seg_o); frame_o every 10 cycles.
REQ-031 SHALL verify tearing: change ones 7'h5B→7'h4F in the 2nd TENS cycle → current ONES slot still 7'h5B; next frame 7'h4F.
REQ-032 SHALL verify leading-zero: tens=7'h3F, blank_lz_i=1 → TENS slot dark; with blank_lz_i=0 → 2'b10/7'h3F.
REQ-033 SHALL verify blink: blink_i=1 for 1000 cycles → enables active cycles 0–249, dark 250–499, active 500–749, dark 750–999; frame_o continues every 10 cycles.
REQ-034 SHALL verify reset: assert rst_ni=0 in the 3rd ONES cycle between clock edges → outputs 0 within the same time step; after release, first cycle has frame_o=1 and dig_en_o=2'b10.
REQ-035 SHALL verify GAP_CYCLES=0 build: 8-cycle frame, enables alternate 10/01 with no dark cycle and never 2'b11.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared scoreboard display definitions: scan-slot encoding and segment constants.
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_TENS  = 2'd0,
        ST_GAP_A = 2'd1,
        ST_ONES  = 2'd2,
        ST_GAP_B = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Slot order TENS, GAP_A, ONES, GAP_B; gaps are skipped when the build has none.
    function automatic scan_state_e next_slot(input scan_state_e s, input bit has_gap);
        scan_state_e n;
        case (s)
            ST_TENS:  n = has_gap ? ST_GAP_A : ST_ONES;
            ST_GAP_A: n = ST_ONES;
            ST_ONES:  n = has_gap ? ST_GAP_B : ST_TENS;
            default:  n = ST_TENS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit-pattern inputs and multiplexed display outputs of the scan driver.
interface seg_scan_driver_if;
    logic [6:0] seg_tens_i;
    logic [6:0] seg_ones_i;
    logic       blank_lz_i;
    logic       blink_i;
    logic [6:0] seg_o;
    logic [1:0] dig_en_o;
    logic       frame_o;

    modport master (
        output seg_tens_i, seg_ones_i, blank_lz_i, blink_i,
        input  seg_o, dig_en_o, frame_o
    );

    modport slave (
        input  seg_tens_i, seg_ones_i, blank_lz_i, blink_i,
        output seg_o, dig_en_o, frame_o
    );
endinterface

// File: rtl/seg_scan_driver_blink_gen.sv
// Free-running blink phase counter; off_phase marks the dark half of each period.
module blink_gen #(
    parameter int BLINK_HALF = 250
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic enable,
    output logic off_phase
);
    localparam int PERIOD = 2 * BLINK_HALF;
    localparam int BW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [BW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)                        r_cnt <= '0;
        else if (!enable)                   r_cnt <= '0;
        else if (r_cnt == BW'(PERIOD - 1))  r_cnt <= '0;
        else                                r_cnt <= r_cnt + 1'b1;
    end

    // Counter value before the edge decides the slot, so phase 0 starts lit.
    assign off_phase = enable && (r_cnt >= BW'(BLINK_HALF));
endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment scanner with dark gaps, leading-zero blank and blink.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int BLINK_HALF   = 250
) (
    input  logic               clk_1khz_i,
    input  logic               rst_ni,
    seg_scan_driver_if.slave   bus
);
    localparam int MAXC    = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAXC + 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    scan_state_e   r_state, w_nxt;
    logic [CW-1:0] r_cnt, w_nxt_cnt, w_last;
    logic          r_run, w_enter;
    logic [6:0]    r_tens_sh, r_ones_sh, w_tens, w_ones;
    logic          r_blank_sh, w_blank;
    logic [6:0]    r_seg;
    logic [1:0]    r_dig;
    logic          r_frame;
    logic          w_off;

    blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk       (clk_1khz_i),
        .rst_ni    (rst_ni),
        .enable    (bus.blink_i),
        .off_phase (w_off)
    );

    // r_run stays low after reset so the first edge enters a fresh TENS slot.
    always_comb begin
        w_last    = (r_state == ST_TENS || r_state == ST_ONES) ? DWELL_LAST : GAP_LAST;
        w_nxt     = r_state;
        w_nxt_cnt = r_cnt + 1'b1;
        w_enter   = 1'b0;
        if (!r_run) begin
            w_nxt     = ST_TENS;
            w_nxt_cnt = '0;
            w_enter   = 1'b1;
        end else if (r_cnt == w_last) begin
            w_nxt     = next_slot(r_state, HAS_GAP);
            w_nxt_cnt = '0;
            w_enter   = (w_nxt == ST_TENS);
        end
        w_tens  = w_enter ? bus.seg_tens_i : r_tens_sh;
        w_ones  = w_enter ? bus.seg_ones_i : r_ones_sh;
        w_blank = w_enter ? bus.blank_lz_i : r_blank_sh;
    end

    always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_TENS;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_tens_sh  <= SEG_BLANK;
            r_ones_sh  <= SEG_BLANK;
            r_blank_sh <= 1'b0;
            r_seg      <= SEG_BLANK;
            r_dig      <= 2'b00;
            r_frame    <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_nxt;
            r_cnt   <= w_nxt_cnt;
            r_frame <= w_enter;
            if (w_enter) begin
                r_tens_sh  <= bus.seg_tens_i;
                r_ones_sh  <= bus.seg_ones_i;
                r_blank_sh <= bus.blank_lz_i;
            end
            // Outputs follow the slot being entered; one state means at most one enable.
            r_dig <= 2'b00;
            r_seg <= SEG_BLANK;
            if (!w_off) begin
                case (w_nxt)
                    ST_TENS: if (!(w_blank && w_tens == SEG_ZERO)) begin
                        r_dig <= 2'b10;
                        r_seg <= w_tens;
                    end
                    ST_ONES: begin
                        r_dig <= 2'b01;
                        r_seg <= w_ones;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.seg_o    = r_seg;
    assign bus.dig_en_o = r_dig;
    assign bus.frame_o  = r_frame;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: scan order, tearing, leading-zero, blink, async reset, gapless build.
module tb_seg_scan_driver;
    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_driver_if bus0 ();
    seg_scan_driver_if bus1 ();

    seg_scan_driver #(.DWELL_CYCLES(4), .GAP_CYCLES(1), .BLINK_HALF(250)) u_dut (
        .clk_1khz_i (clk),
        .rst_ni     (rst_ni),
        .bus        (bus0.slave)
    );

    seg_scan_driver #(.DWELL_CYCLES(4), .GAP_CYCLES(0), .BLINK_HALF(250)) u_dut_ng (
        .clk_1khz_i (clk),
        .rst_ni     (rst_ni),
        .bus        (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] t, input logic [6:0] o, input logic bl, input logic bk);
        bus0.seg_tens_i = t; bus0.seg_ones_i = o; bus0.blank_lz_i = bl; bus0.blink_i = bk;
        bus1.seg_tens_i = t; bus1.seg_ones_i = o; bus1.blank_lz_i = bl; bus1.blink_i = bk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 10-cycle frame of the gapped build, starting at the TENS entry edge.
    task automatic run_frame(input string nm, input logic [6:0] et, input logic [6:0] eo,
                             input bit dark_t, input bit chg, input logic [6:0] new_ones);
        logic [1:0] ed;
        logic [6:0] es;
        for (int p = 0; p < 10; p++) begin
            step();
            if (p < 4)           begin ed = dark_t ? 2'b00 : 2'b10; es = dark_t ? 7'h00 : et; end
            else if (p >= 5 && p < 9) begin ed = 2'b01; es = eo; end
            else                 begin ed = 2'b00; es = 7'h00; end
            chk($sformatf("%s p%0d dig", nm, p), 32'(bus0.dig_en_o), 32'(ed));
            chk($sformatf("%s p%0d seg", nm, p), 32'(bus0.seg_o), 32'(es));
            chk($sformatf("%s p%0d frame", nm, p), 32'(bus0.frame_o), 32'(p == 0));
            if (chg && p == 1) begin
                bus0.seg_ones_i = new_ones;
                bus1.seg_ones_i = new_ones;
            end
        end
    endtask

    initial begin
        logic [1:0] ed;
        logic [6:0] es;
        int p, q;
        bit dark;

        drive(7'h06, 7'h5B, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        repeat (3) step();
        chk("rst dig",    32'(bus0.dig_en_o), 32'h0);
        chk("rst seg",    32'(bus0.seg_o),    32'h0);
        chk("rst frame",  32'(bus0.frame_o),  32'h0);
        chk("rst ng dig", 32'(bus1.dig_en_o), 32'h0);

        // Scan order on both builds from the first edge after release.
        rst_ni = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            p = k % 10;
            q = k % 8;
            if (p < 4)                begin ed = 2'b10; es = 7'h06; end
            else if (p >= 5 && p < 9) begin ed = 2'b01; es = 7'h5B; end
            else                      begin ed = 2'b00; es = 7'h00; end
            chk($sformatf("scan k%0d dig", k),   32'(bus0.dig_en_o), 32'(ed));
            chk($sformatf("scan k%0d seg", k),   32'(bus0.seg_o),    32'(es));
            chk($sformatf("scan k%0d frame", k), 32'(bus0.frame_o),  32'(p == 0));
            chk($sformatf("ng k%0d dig", k),   32'(bus1.dig_en_o), (q < 4) ? 32'h2 : 32'h1);
            chk($sformatf("ng k%0d seg", k),   32'(bus1.seg_o),    (q < 4) ? 32'h06 : 32'h5B);
            chk($sformatf("ng k%0d frame", k), 32'(bus1.frame_o),  32'(q == 0));
            chk($sformatf("ng k%0d not11", k), 32'(bus1.dig_en_o != 2'b11), 32'h1);
        end

        run_frame("tear", 7'h06, 7'h5B, 1'b0, 1'b1, 7'h4F);
        run_frame("tear_next", 7'h06, 7'h4F, 1'b0, 1'b0, 7'h00);

        drive(7'h3F, 7'h4F, 1'b1, 1'b0);
        run_frame("lz_on", 7'h3F, 7'h4F, 1'b1, 1'b0, 7'h00);
        drive(7'h3F, 7'h4F, 1'b0, 1'b0);
        run_frame("lz_off", 7'h3F, 7'h4F, 1'b0, 1'b0, 7'h00);

        drive(7'h3F, 7'h4F, 1'b0, 1'b1);
        for (int b = 0; b < 1000; b++) begin
            step();
            p = b % 10;
            dark = (b % 500) >= 250;
            if (dark)                 begin ed = 2'b00; es = 7'h00; end
            else if (p < 4)           begin ed = 2'b10; es = 7'h3F; end
            else if (p >= 5 && p < 9) begin ed = 2'b01; es = 7'h4F; end
            else                      begin ed = 2'b00; es = 7'h00; end
            chk($sformatf("blink b%0d dig", b),   32'(bus0.dig_en_o), 32'(ed));
            chk($sformatf("blink b%0d seg", b),   32'(bus0.seg_o),    32'(es));
            chk($sformatf("blink b%0d frame", b), 32'(bus0.frame_o),  32'(p == 0));
        end

        // Reset asserted between edges in the 3rd ONES cycle.
        drive(7'h06, 7'h5B, 1'b0, 1'b0);
        repeat (8) step();
        chk("pre_rst dig", 32'(bus0.dig_en_o), 32'h1);
        chk("pre_rst seg", 32'(bus0.seg_o),    32'h5B);
        #2 rst_ni = 1'b0;
        #1;
        chk("async dig",    32'(bus0.dig_en_o), 32'h0);
        chk("async seg",    32'(bus0.seg_o),    32'h0);
        chk("async frame",  32'(bus0.frame_o),  32'h0);
        chk("async ng dig", 32'(bus1.dig_en_o), 32'h0);
        repeat (2) step();
        chk("held dig", 32'(bus0.dig_en_o), 32'h0);
        rst_ni = 1'b1;
        step();
        chk("post_rst frame",    32'(bus0.frame_o),  32'h1);
        chk("post_rst dig",      32'(bus0.dig_en_o), 32'h2);
        chk("post_rst seg",      32'(bus0.seg_o),    32'h06);
        chk("post_rst ng frame", 32'(bus1.frame_o),  32'h1);
        chk("post_rst ng dig",   32'(bus1.dig_en_o), 32'h2);
        step();
        chk("post_rst2 frame",   32'(bus0.frame_o),  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
